// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//
// Purpose: shared definitions for the boot-time instruction image loader.
//   - loader FSM state encoding
//   - default frame start marker
//   - frame field widths (32-bit word count, 8-bit XOR checksum)
//   - small decode helpers used to build the registered status outputs
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    // Loader FSM states. DONE and ERR are terminal until reset.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    // Default frame start marker.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Frame field widths.
    localparam int unsigned LEN_WIDTH  = 32;
    localparam int unsigned CSUM_WIDTH = 8;

    // Bytes per memory word (little-endian byte quadruple).
    localparam int unsigned BYTES_PER_WORD = 4;

    // A frame is "in progress" from the length field until the checksum
    // byte has been judged.
    function automatic logic state_is_busy(input state_t s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_WRITE) || (s == ST_CHK);
    endfunction

    // The CPU may run only after a good load, or while idle when the
    // power-up hold is disabled.
    function automatic logic state_holds_cpu(input state_t s, input logic boot_hold);
        logic release_cpu;
        release_cpu = (s == ST_DONE) || ((s == ST_IDLE) && !boot_hold);
        return !release_cpu;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Purpose: receives a framed instruction image over a byte valid/ready stream
// and writes it, one 32-bit little-endian word at a time, into port A of the
// CPU's dual-port instruction/data BRAM. The CPU reset request stays asserted
// until a complete frame with a matching checksum has been loaded.
//
// Frame: SYNC_BYTE, N[7:0], N[15:8], N[23:16], N[31:24], 4*N data bytes,
//        XOR of all data bytes.
//
// Ports:
//   sysclk      in   clock, all logic on the rising edge
//   rst         in   synchronous active-high reset
//   rx_data     in   received byte
//   rx_valid    in   rx_data valid
//   rx_ready    out  byte accepted when rx_valid && rx_ready (low only in WRITE)
//   mem_en      out  BRAM port A enable (one-cycle pulse per word)
//   mem_we      out  BRAM port A byte write enables
//   mem_addr    out  BRAM port A word address
//   mem_wdata   out  BRAM port A write data
//   cpu_rst     out  reset request to the CPU core
//   busy        out  frame in progress
//   done        out  frame loaded with good checksum (sticky until rst)
//   error       out  frame rejected (sticky until rst)
//
// All outputs except rx_ready are registered; their next values are decoded
// from the next state so they line up with the state register.
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned BASE_ADDR  = 0,
    parameter bit          BOOT_HOLD  = 1'b1,
    parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Largest accepted word count: the words from BASE_ADDR up to the top of
    // the port A address space. Computed one bit wider than the length field
    // so the comparison cannot overflow.
    localparam logic [LEN_WIDTH:0] W_LEN_LIMIT =
        (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t                 r_state;
    state_t                 w_state_next;

    logic [1:0]             r_lane;       // byte position within the current word
    logic [31:0]            r_shift;      // partially assembled word / length
    logic [LEN_WIDTH-1:0]   r_len;        // word count N of the current frame
    logic [LEN_WIDTH-1:0]   r_word_cnt;   // words written so far
    logic [ADDR_WIDTH-1:0]  r_addr;       // address of the next word to write
    logic [CSUM_WIDTH-1:0]  r_csum;       // running XOR of data bytes

    logic                   r_mem_en;
    logic [3:0]             r_mem_we;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic [31:0]            r_mem_wdata;
    logic                   r_cpu_rst;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_error;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic                   w_rx_ready;
    logic                   w_accept;
    logic                   w_last_lane;
    logic [31:0]            w_word;
    logic [LEN_WIDTH-1:0]   w_word_cnt_inc;
    logic                   w_is_sync;

    // The only cycle a byte cannot be taken is the single write cycle.
    assign w_rx_ready     = (r_state != ST_WRITE);
    assign w_accept       = rx_valid && w_rx_ready;
    assign w_last_lane    = (r_lane == 2'd3);
    assign w_word_cnt_inc = r_word_cnt + 32'd1;
    assign w_is_sync      = (rx_data == SYNC_BYTE);

    // Byte assembler: the incoming byte is inserted into the lane selected by
    // r_lane, all other lanes keep what has been collected so far. On the 4th
    // byte w_word is therefore the complete little-endian word (or length).
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
        assign w_word[8*gi +: 8] = (r_lane == 2'(gi)) ? rx_data : r_shift[8*gi +: 8];
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_sync) begin
                    w_state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_accept && w_last_lane) begin
                    if (w_word == 32'd0) begin
                        // Empty image: only the (zero) checksum follows.
                        w_state_next = ST_CHK;
                    end else if ({1'b0, w_word} > W_LEN_LIMIT) begin
                        // Would run past the top of memory; reject before
                        // any word is written.
                        w_state_next = ST_ERR;
                    end else begin
                        w_state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_accept && w_last_lane) begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_word_cnt_inc == r_len) begin
                    w_state_next = ST_CHK;
                end else begin
                    w_state_next = ST_DATA;
                end
            end
            ST_CHK: begin
                if (w_accept) begin
                    w_state_next = (rx_data == r_csum) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE: w_state_next = ST_DONE;
            ST_ERR:  w_state_next = ST_ERR;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: byte assembly, counters, checksum
    // -------------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_lane     <= 2'd0;
            r_shift    <= 32'd0;
            r_len      <= '0;
            r_word_cnt <= '0;
            r_addr     <= ADDR_WIDTH'(BASE_ADDR);
            r_csum     <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_is_sync) begin
                        r_lane     <= 2'd0;
                        r_shift    <= 32'd0;
                        r_len      <= '0;
                        r_word_cnt <= '0;
                        r_addr     <= ADDR_WIDTH'(BASE_ADDR);
                        r_csum     <= '0;
                    end
                end
                ST_LEN: begin
                    if (w_accept) begin
                        r_shift <= w_word;
                        // The 2-bit lane counter wraps to 0 after the 4th
                        // byte, ready for the first data word.
                        r_lane  <= r_lane + 2'd1;
                        if (w_last_lane) begin
                            r_len <= w_word;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_shift <= w_word;
                        r_lane  <= r_lane + 2'd1;
                        r_csum  <= r_csum ^ rx_data;
                    end
                end
                ST_WRITE: begin
                    r_word_cnt <= w_word_cnt_inc;
                    r_addr     <= r_addr + ADDR_WIDTH'(1);
                end
                default: begin
                    // CHK, DONE, ERR: bytes are judged or discarded only.
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 4'b0000;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
            r_cpu_rst   <= BOOT_HOLD;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            // The write strobe is the WRITE state itself, so it is decoded
            // from the next state to be valid in exactly that cycle.
            r_mem_en <= (w_state_next == ST_WRITE);
            r_mem_we <= {4{w_state_next == ST_WRITE}};

            // Address and data are captured together with the 4th byte so
            // they are stable throughout the WRITE cycle. Outside WRITE they
            // simply hold the last written word.
            if ((r_state == ST_DATA) && w_accept && w_last_lane) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= w_word;
            end

            r_cpu_rst <= state_holds_cpu(w_state_next, BOOT_HOLD);
            r_busy    <= state_is_busy(w_state_next);
            r_done    <= (w_state_next == ST_DONE);
            r_error   <= (w_state_next == ST_ERR);
        end
    end

    assign rx_ready  = w_rx_ready;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_rst   = r_cpu_rst;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader (ADDR_WIDTH = 13, BASE_ADDR = 0,
// BOOT_HOLD = 1). A reference model parses each byte stream by the framing
// rules and predicts the words written, which bytes complete a word, and the
// final status; a negedge monitor logs every port A write of the DUT.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int AW   = 13;
    localparam int BASE = 0;
    localparam int LIMIT = (1 << AW) - BASE;

    typedef logic [7:0] byte_q_t[$];

    logic            sysclk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      rx_data = 8'h00;
    logic            rx_valid = 1'b0;
    logic            rx_ready;
    logic            mem_en;
    logic [3:0]      mem_we;
    logic [AW-1:0]   mem_addr;
    logic [31:0]     mem_wdata;
    logic            cpu_rst;
    logic            busy;
    logic            done;
    logic            error;

    int checks = 0;
    int errors = 0;

    // Model results
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_flag[$];   // per byte: this byte completes a data word
    int          exp_status;    // 0 = no verdict yet, 1 = done, 2 = error

    // Observed writes
    int          log_addr[$];
    logic [31:0] log_data[$];
    logic [31:0] obs_mem [0:(1<<AW)-1];
    int          stall_cnt;

    imem_loader #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE),
        .BOOT_HOLD  (1'b1),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 sysclk = ~sysclk;

    // BRAM port A stand-in: record every write.
    always @(negedge sysclk) begin
        if (mem_en === 1'b1) begin
            log_addr.push_back(int'(mem_addr));
            log_data.push_back(mem_wdata);
            obs_mem[mem_addr] = mem_wdata;
            checks++;
            if (mem_we !== 4'b1111) begin
                errors++;
                $display("FAIL write_we actual=%b required=1111", mem_we);
            end
        end
    end

    // Reference model: parse the stream by the frame rules.
    task automatic model_run(input byte_q_t b);
        int i;
        logic [31:0] n;
        logic [31:0] w;
        logic [7:0] x;
        exp_addr.delete(); exp_data.delete(); exp_flag.delete();
        exp_status = 0;
        i = 0;
        while (i < b.size() && b[i] != 8'hA5) begin exp_flag.push_back(0); i++; end
        if (i < b.size()) begin exp_flag.push_back(0); i++; end
        if (b.size() - i < 4) begin
            while (exp_flag.size() < b.size()) exp_flag.push_back(0);
            return;
        end
        n = {b[i+3], b[i+2], b[i+1], b[i]};
        repeat (4) exp_flag.push_back(0);
        i += 4;
        x = 8'h00;
        if (n > 32'(LIMIT)) begin
            exp_status = 2;
        end else begin
            for (int k = 0; k < int'(n); k++) begin
                if (i + 4 > b.size()) break;
                w = {b[i+3], b[i+2], b[i+1], b[i]};
                x = x ^ b[i] ^ b[i+1] ^ b[i+2] ^ b[i+3];
                exp_addr.push_back(BASE + k);
                exp_data.push_back(w);
                exp_flag.push_back(0); exp_flag.push_back(0);
                exp_flag.push_back(0); exp_flag.push_back(1);
                i += 4;
            end
            if (exp_addr.size() == int'(n) && i < b.size()) begin
                exp_status = (b[i] == x) ? 1 : 2;
            end
        end
        while (exp_flag.size() < b.size()) exp_flag.push_back(0);
    endtask

    // Build a frame of n random words; optionally corrupt the checksum.
    task automatic make_frame(input int n, input bit corrupt, output byte_q_t f);
        logic [7:0] x;
        logic [7:0] v;
        f = {};
        x = 8'h00;
        f.push_back(8'hA5);
        f.push_back(n[7:0]); f.push_back(n[15:8]);
        f.push_back(n[23:16]); f.push_back(n[31:24]);
        for (int k = 0; k < 4 * n; k++) begin
            v = 8'($urandom);
            x ^= v;
            f.push_back(v);
        end
        f.push_back(corrupt ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
    endtask

    task automatic tb_reset();
        rx_valid = 1'b0;
        rst = 1'b1;
        @(posedge sysclk); #1;
        @(posedge sysclk); #1;
        rst = 1'b0;
        log_addr.delete();
        log_data.delete();
    endtask

    // Drive bytes (with random idle gaps up to gap_max). Checks, at the
    // sample after each accepted byte that completes a word, that the write
    // is in progress with the model's address and data.
    task automatic send(input byte_q_t q, input int gap_max);
        int gap;
        int waitc;
        int w;
        bit acc;
        w = 0;
        stall_cnt = 0;
        for (int k = 0; k < q.size(); k++) begin
            gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            rx_valid = 1'b0;
            repeat (gap) begin @(posedge sysclk); #1; end
            rx_valid = 1'b1;
            rx_data = q[k];
            acc = 1'b0;
            waitc = 0;
            while (!acc) begin
                acc = rx_ready;
                if (!acc) begin
                    stall_cnt++;
                    checks++;
                    if (mem_en !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_outside_write mem_en actual=%b required=1", mem_en);
                    end
                end
                @(posedge sysclk); #1;
                waitc++;
                if (!acc && waitc > 8) begin
                    errors++;
                    $display("FAIL byte_timeout byte=%0d cycles=%0d required<=8", k, waitc);
                    break;
                end
            end
            if (k < exp_flag.size() && exp_flag[k]) begin
                checks++;
                if (mem_en !== 1'b1 || mem_we !== 4'b1111 ||
                    int'(mem_addr) !== exp_addr[w] || mem_wdata !== exp_data[w]) begin
                    errors++;
                    $display("FAIL write_latency word=%0d actual en=%b we=%b addr=%0d data=%h required en=1 we=1111 addr=%0d data=%h",
                             w, mem_en, mem_we, mem_addr, mem_wdata, exp_addr[w], exp_data[w]);
                end
                w++;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        tb_reset();
        checks++;
        if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready actual=%b required=1", rx_ready); end
        checks++;
        if (mem_en !== 1'b0 || mem_we !== 4'b0000) begin
            errors++; $display("FAIL reset_mem_en actual en=%b we=%b required en=0 we=0000", mem_en, mem_we);
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== 32'd0) begin
            errors++; $display("FAIL reset_mem_bus actual addr=%0d data=%h required addr=0 data=0", mem_addr, mem_wdata);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL reset_status actual busy=%b done=%b error=%b required 0 0 0", busy, done, error);
        end
        checks++;
        if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst actual=%b required=1", cpu_rst); end
        $display("test_reset done");
    endtask

    task automatic test_good_frame(input bit bad_csum);
        byte_q_t f;
        f = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00,
              8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        if (bad_csum) f[13] = 8'h2B;
        tb_reset();
        model_run(f);
        send(f, 0);
        checks++;
        if (log_addr.size() != 2 || log_addr[0] != 0 || log_data[0] !== 32'h12345678 ||
            log_addr[1] != 1 || log_data[1] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL fixed_writes actual count=%0d required 2 words 12345678@0 DEADBEEF@1", log_addr.size());
        end
        checks++;
        if (obs_mem[0] !== 32'h12345678 || obs_mem[1] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL fixed_mem actual %h %h required 12345678 DEADBEEF", obs_mem[0], obs_mem[1]);
        end
        checks++;
        if (bad_csum) begin
            if (error !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL bad_csum_status actual err=%b done=%b cpu_rst=%b busy=%b required 1 0 1 0", error, done, cpu_rst, busy);
            end
        end else begin
            if (error !== 1'b0 || done !== 1'b1 || cpu_rst !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL good_status actual err=%b done=%b cpu_rst=%b busy=%b required 0 1 0 0", error, done, cpu_rst, busy);
            end
        end
        $display("test_good_frame bad_csum=%0d writes=%0d", bad_csum, log_addr.size());
    endtask

    task automatic test_junk();
        byte_q_t junk;
        byte_q_t f;
        junk = '{8'h00, 8'hFF, 8'h5A};
        f = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00,
              8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        tb_reset();
        model_run(junk);
        send(junk, 1);
        checks++;
        if (busy !== 1'b0 || log_addr.size() != 0) begin
            errors++; $display("FAIL junk_idle actual busy=%b writes=%0d required busy=0 writes=0", busy, log_addr.size());
        end
        model_run(f);
        send(f, 0);
        checks++;
        if (log_addr.size() != 2 || log_data[0] !== 32'h12345678 || log_data[1] !== 32'hDEADBEEF ||
            done !== 1'b1 || cpu_rst !== 1'b0) begin
            errors++; $display("FAIL junk_then_frame actual writes=%0d done=%b cpu_rst=%b required 2 1 0", log_addr.size(), done, cpu_rst);
        end
        $display("test_junk writes=%0d", log_addr.size());
    endtask

    task automatic test_len_limits();
        byte_q_t f;
        // N = 0, checksum 00
        f = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tb_reset();
        model_run(f);
        send(f, 0);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || log_addr.size() != 0) begin
            errors++; $display("FAIL len_zero actual done=%b err=%b writes=%0d required 1 0 0", done, error, log_addr.size());
        end
        // N = 0x2001: one word too many
        f = '{8'hA5, 8'h01, 8'h20, 8'h00, 8'h00};
        tb_reset();
        model_run(f);
        send(f, 0);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || exp_status != 2) begin
            errors++; $display("FAIL len_over actual err=%b busy=%b required err=1 busy=0", error, busy);
        end
        repeat (3) begin @(posedge sysclk); #1; end
        checks++;
        if (log_addr.size() != 0 || cpu_rst !== 1'b1) begin
            errors++; $display("FAIL len_over_nowrite actual writes=%0d cpu_rst=%b required 0 1", log_addr.size(), cpu_rst);
        end
        // N = 0x2000: exactly fills memory, must be accepted
        f = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h00};
        tb_reset();
        model_run(f);
        send(f, 0);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL len_max actual err=%b busy=%b required err=0 busy=1", error, busy);
        end
        $display("test_len_limits done");
    endtask

    task automatic test_back_to_back();
        byte_q_t f;
        int n;
        for (int it = 0; it < 3; it++) begin
            n = $urandom_range(3, 8);
            make_frame(n, 1'b0, f);
            tb_reset();
            model_run(f);
            send(f, 0);
            checks++;
            if (stall_cnt != n) begin
                errors++; $display("FAIL b2b_stalls actual=%0d required=%0d", stall_cnt, n);
            end
            checks++;
            if (log_addr.size() != exp_addr.size() || done !== 1'b1) begin
                errors++; $display("FAIL b2b_result actual writes=%0d done=%b required %0d 1", log_addr.size(), done, exp_addr.size());
            end else begin
                for (int k = 0; k < exp_addr.size(); k++) begin
                    checks++;
                    if (log_addr[k] != exp_addr[k] || log_data[k] !== exp_data[k]) begin
                        errors++; $display("FAIL b2b_word%0d actual %h@%0d required %h@%0d", k, log_data[k], log_addr[k], exp_data[k], exp_addr[k]);
                    end
                end
            end
            $display("test_back_to_back n=%0d stalls=%0d", n, stall_cnt);
        end
    endtask

    task automatic test_random();
        byte_q_t f;
        byte_q_t s;
        int n;
        bit bad;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(0, 5);
            bad = 1'($urandom_range(0, 1));
            make_frame(n, bad, f);
            s = {};
            repeat ($urandom_range(0, 3)) s.push_back(8'($urandom_range(0, 8'hA4)));
            s = {s, f};
            tb_reset();
            model_run(s);
            send(s, 2);
            checks++;
            if (done !== (exp_status == 1) || error !== (exp_status == 2) ||
                cpu_rst !== (exp_status != 1)) begin
                errors++; $display("FAIL rand_status it=%0d actual done=%b err=%b cpu_rst=%b model_status=%0d", it, done, error, cpu_rst, exp_status);
            end
            checks++;
            if (log_addr.size() != exp_addr.size()) begin
                errors++; $display("FAIL rand_count it=%0d actual=%0d required=%0d", it, log_addr.size(), exp_addr.size());
            end else begin
                for (int k = 0; k < exp_addr.size(); k++) begin
                    checks++;
                    if (log_addr[k] != exp_addr[k] || log_data[k] !== exp_data[k]) begin
                        errors++; $display("FAIL rand_word it=%0d k=%0d actual %h@%0d required %h@%0d", it, k, log_data[k], log_addr[k], exp_data[k], exp_addr[k]);
                    end
                end
            end
            $display("test_random it=%0d n=%0d bad=%0d status=%0d", it, n, bad, exp_status);
        end
    endtask

    task automatic test_reset_mid();
        byte_q_t f;
        byte_q_t part;
        make_frame(3, 1'b0, f);
        part = f[0:10];   // sync + length + 6 data bytes
        tb_reset();
        model_run(part);
        send(part, 0);
        rst = 1'b1;
        @(posedge sysclk); #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || cpu_rst !== 1'b1 || mem_en !== 1'b0) begin
            errors++; $display("FAIL midrst_status actual busy=%b done=%b err=%b cpu_rst=%b en=%b required 0 0 0 1 0", busy, done, error, cpu_rst, mem_en);
        end
        repeat (3) begin @(posedge sysclk); #1; end
        checks++;
        if (log_addr.size() != 1 || log_addr[0] != 0 || log_data[0] !== exp_data[0]) begin
            errors++; $display("FAIL midrst_writes actual count=%0d required 1 word at 0", log_addr.size());
        end
        log_addr.delete();
        log_data.delete();
        make_frame(2, 1'b0, f);
        model_run(f);
        send(f, 1);
        checks++;
        if (log_addr.size() != 2 || log_addr[0] != 0 || log_data[0] !== exp_data[0] ||
            log_data[1] !== exp_data[1] || done !== 1'b1) begin
            errors++; $display("FAIL midrst_reload actual count=%0d done=%b required 2 words from 0, done=1", log_addr.size(), done);
        end
        $display("test_reset_mid reload_writes=%0d", log_addr.size());
    endtask

    initial begin
        test_reset();
        test_good_frame(1'b0);
        test_good_frame(1'b1);
        test_junk();
        test_len_limits();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
